vid_to_axis_bridge: RTL

- Downstream of the sync/pattern video generator. Consumes its registered parallel video (DE, FV, 8-bit R/G/B) and re-emits it as a 24-bit AXI4-Stream video interface with tuser = start-of-frame and tlast = end-of-line.
- Contains a 1-pixel look-ahead stage, an elastic FIFO that absorbs downstream backpressure, and a frame-aligned state machine.
- On overflow, the rest of the current frame is dropped and the block re-locks at the next frame.

---
 rtl/vid_to_axis_bridge.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/vid_to_axis_bridge.sv
// ---------------------------------------------------------------------------
// vid_to_axis_bridge
//
// Converts registered parallel video (DE, FV, 8-bit R/G/B) from the sync /
// pattern generator into a 24-bit AXI4-Stream video stream:
//   tuser = start-of-frame (first pixel of a locked frame)
//   tlast = end-of-line (last pixel of each DE run)
//
// Datapath: 1-pixel look-ahead stage -> elastic FIFO -> FWFT output register.
// The look-ahead stage is what lets tlast be known when a pixel is written:
// the pixel is held for one cycle and tagged with tlast = ~de_i of the
// following cycle.
//
// Control: frame-aligned FSM (SYNC_WAIT / RUN / DROP). Pixels are only
// written while RUN. If a write is needed while the FIFO is full, the rest of
// the frame is dropped and the block re-locks at the next frame start.
//
// Optional feature (macro VID_AXIS_LINE_CHECK_EN):
//   defined   -> per-line pixel counter; line_err_o is set when a line length
//                differs from H_ACTIVE.
//   undefined -> no counter; line_err_o is tied to 0.
//
// Ports:
//   clk_i            pixel clock
//   resetb_i         asynchronous active-low reset
//   enable_i         allows locking onto the next frame
//   de_i, fv_i       data enable / frame valid, active high
//   red_i/green_i/blue_i  pixel components
//   err_clr_i        single-cycle pulse, clears sticky flags
//   m_axis_tdata_o   {red, green, blue}
//   m_axis_tvalid_o / m_axis_tready_i / m_axis_tuser_o / m_axis_tlast_o
//   overflow_o       sticky: write needed while FIFO full
//   line_err_o       sticky: line length differed from H_ACTIVE
//   fifo_level_o     current FIFO occupancy
// ---------------------------------------------------------------------------
module vid_to_axis_bridge #(
  parameter int FIFO_DEPTH = 1024,
  parameter int ADDR_W     = 10,
  parameter int H_ACTIVE   = 640
) (
  input  logic              clk_i,
  input  logic              resetb_i,
  input  logic              enable_i,
  input  logic              de_i,
  input  logic              fv_i,
  input  logic [7:0]        red_i,
  input  logic [7:0]        green_i,
  input  logic [7:0]        blue_i,
  input  logic              err_clr_i,
  output logic [23:0]       m_axis_tdata_o,
  output logic              m_axis_tvalid_o,
  input  logic              m_axis_tready_i,
  output logic              m_axis_tuser_o,
  output logic              m_axis_tlast_o,
  output logic              overflow_o,
  output logic              line_err_o,
  output logic [ADDR_W:0]   fifo_level_o
);

  localparam int              PTR_W   = ADDR_W + 1;
  localparam logic [ADDR_W:0] PTR_ONE = PTR_W'(1);

  // Elaboration-time sanity check of the configuration.
  if (FIFO_DEPTH < 4 || FIFO_DEPTH != (1 << ADDR_W) ||
      H_ACTIVE < 1 || H_ACTIVE > 4095) begin : g_cfg_check
    $error("vid_to_axis_bridge: invalid FIFO_DEPTH / ADDR_W / H_ACTIVE");
  end

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    RUN       = 2'd1,
    DROP      = 2'd2
  } state_t;

  state_t state;
  logic   sof_pending;

  // Frame-valid history. fv_seen_low guards against treating an already
  // high fv_i right after reset as a rising edge: only a frame whose start
  // was actually observed may be locked onto.
  logic fv_q;
  logic fv_seen_low;
  logic fv_rise;
  logic fv_fall;
  logic lock;

  // Look-ahead stage
  logic [23:0] pix_p1;
  logic        vld_p1;

  // FIFO
  logic [25:0]     mem [FIFO_DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [ADDR_W:0] level;
  logic            full;
  logic            empty;
  logic            wr_en;
  logic            rd_en;
  logic            ovf_evt;

  // Output register
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_user;
  logic        out_last;
  logic        overflow;

  assign fv_rise = fv_i && !fv_q && fv_seen_low;
  assign fv_fall = !fv_i && fv_q;
  assign lock    = (state == SYNC_WAIT) && fv_rise && enable_i;

  // Full is judged on the pointers before any same-cycle read, so a read
  // never makes room for a write in the same cycle.
  assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign wr_en   = vld_p1 && (state == RUN) && !full;
  assign ovf_evt = vld_p1 && (state == RUN) && full;
  assign rd_en   = !empty && (!out_valid || m_axis_tready_i);

  // ---- input history / look-ahead control (p0 -> p1) ----
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fv_q        <= 1'b0;
      fv_seen_low <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      fv_q   <= fv_i;
      vld_p1 <= de_i;
      if (!fv_i) fv_seen_low <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (de_i) pix_p1 <= {red_i, green_i, blue_i};
  end

  // ---- frame FSM ----
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state       <= SYNC_WAIT;
      sof_pending <= 1'b0;
    end else begin
      case (state)
        SYNC_WAIT: begin
          if (fv_rise && enable_i) begin
            state       <= RUN;
            sof_pending <= 1'b1;
          end
        end
        RUN: begin
          if (wr_en) sof_pending <= 1'b0;
          // The final look-ahead push happens on the same edge as the fv
          // fall, so leaving RUN here still writes the last pixel.
          if (fv_fall)      state <= SYNC_WAIT;
          else if (ovf_evt) state <= DROP;
        end
        DROP: begin
          if (fv_fall) state <= SYNC_WAIT;
        end
        default: state <= SYNC_WAIT;
      endcase
    end
  end

  // ---- FIFO write (p1 -> p2) ----
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr[ADDR_W-1:0]] <= {sof_pending, !de_i, pix_p1};
  end

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      level <= level + PTR_W'(wr_en) - PTR_W'(rd_en);
    end
  end

  // ---- FWFT output register (p2 -> p3) ----
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      out_valid <= 1'b0;
      out_user  <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (rd_en) begin
      out_valid                      <= 1'b1;
      {out_user, out_last, out_data} <= mem[rd_ptr[ADDR_W-1:0]];
    end else if (m_axis_tready_i) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overflow: a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i)      overflow <= 1'b0;
    else if (ovf_evt)   overflow <= 1'b1;
    else if (err_clr_i) overflow <= 1'b0;
  end

`ifdef VID_AXIS_LINE_CHECK_EN
  localparam logic [12:0] LINE_LEN = 13'(H_ACTIVE);

  logic [11:0] line_cnt;
  logic        line_err;
  logic        line_err_set;

  // line_cnt holds pixels already written on this line, so the pixel being
  // written with tlast makes the length line_cnt + 1.
  assign line_err_set = wr_en && !de_i && (({1'b0, line_cnt} + 13'd1) != LINE_LEN);

  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      line_cnt <= '0;
      line_err <= 1'b0;
    end else begin
      if (lock) begin
        line_cnt <= '0;
      end else if (wr_en) begin
        if (!de_i)                  line_cnt <= '0;
        else if (line_cnt != 12'hFFF) line_cnt <= line_cnt + 12'd1;
      end
      if (line_err_set)   line_err <= 1'b1;
      else if (err_clr_i) line_err <= 1'b0;
    end
  end

  assign line_err_o = line_err;
`else
  assign line_err_o = 1'b0;
`endif

  assign m_axis_tdata_o  = out_data;
  assign m_axis_tvalid_o = out_valid;
  assign m_axis_tuser_o  = out_user;
  assign m_axis_tlast_o  = out_last;
  assign overflow_o      = overflow;
  assign fifo_level_o    = level;

endmodule
